// File: rtl/lives_manager.sv
// lives_manager
//   Tracks lives for NUM_PLAYERS independent players. Each player has
//   rising-edge hit/bonus detection and a post-hit invulnerability window.
//   The block drives thermometer heart masks, sticky death flags, one-cycle
//   life-lost pulses and a global game_over. All outputs are registered.
//
// Ports
//   clk           system clock
//   resetN        asynchronous active-low reset
//   game_restart  synchronous re-initialise of every player (active-high)
//   hit           per-player damage request; the rising edge counts
//   bonus_life    per-player extra-life request; the rising edge counts
//   lives_count   packed lives, player p at [p*LIFE_W +: LIFE_W]
//   heart_mask    thermometer, player p at [p*MAX_LIVES +: MAX_LIVES]
//   invulnerable  high while the player is in INVULN
//   player_died   sticky, high while the player is in DEAD
//   life_lost     one-cycle pulse on each accepted hit
//   game_over     sticky, high when every player is DEAD
//
// Per-player FSM
//   state  | meaning
//   ALIVE  | accepts hits and bonuses
//   INVULN | hits ignored, bonuses applied, down-counter running
//   DEAD   | lives = 0, all events ignored until restart/reset
module lives_manager #(
    parameter int NUM_PLAYERS   = 2,
    parameter int MAX_LIVES     = 5,
    parameter int START_LIVES   = 3,
    parameter int INVULN_CYCLES = 50000000,
    parameter int LIFE_W        = $clog2(MAX_LIVES + 1)
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            game_restart,
    input  logic [NUM_PLAYERS-1:0]          hit,
    input  logic [NUM_PLAYERS-1:0]          bonus_life,
    output logic [NUM_PLAYERS*LIFE_W-1:0]   lives_count,
    output logic [NUM_PLAYERS*MAX_LIVES-1:0] heart_mask,
    output logic [NUM_PLAYERS-1:0]          invulnerable,
    output logic [NUM_PLAYERS-1:0]          player_died,
    output logic [NUM_PLAYERS-1:0]          life_lost,
    output logic                            game_over
);

    localparam logic [1:0] ALIVE  = 2'd0;
    localparam logic [1:0] INVULN = 2'd1;
    localparam logic [1:0] DEAD   = 2'd2;

    // The timer holds INVULN_CYCLES-1 down to 0, so it only needs that range.
    localparam int TMR_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(INVULN_CYCLES - 1);

    localparam logic [LIFE_W-1:0] START_L = LIFE_W'(START_LIVES);
    localparam logic [LIFE_W-1:0] MAX_L   = LIFE_W'(MAX_LIVES);
    localparam logic [LIFE_W-1:0] ONE_L   = LIFE_W'(1);

    localparam int unsigned START_MASK_I = (1 << START_LIVES) - 1;
    localparam logic [MAX_LIVES-1:0] START_MASK = START_MASK_I[MAX_LIVES-1:0];

    logic [NUM_PLAYERS-1:0] hit_d;
    logic [NUM_PLAYERS-1:0] bonus_d;
    logic [NUM_PLAYERS-1:0] dead_nxt;

    // Edge history updates in every state, including during restart.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_d   <= '0;
            bonus_d <= '0;
        end else begin
            hit_d   <= hit;
            bonus_d <= bonus_life;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic                 hit_e;
        logic                 bonus_e;
        logic [1:0]           st_q;
        logic [1:0]           st_nxt;
        logic [LIFE_W-1:0]    lives_q;
        logic [LIFE_W-1:0]    lives_nxt;
        logic [TMR_W-1:0]     tmr_q;
        logic [TMR_W-1:0]     tmr_nxt;
        logic                 lost_nxt;
        logic [MAX_LIVES-1:0] hmask_q;
        logic [MAX_LIVES-1:0] hmask_nxt;
        logic                 inv_q;
        logic                 died_q;
        logic                 lost_q;

        assign hit_e   = hit[p] & ~hit_d[p];
        assign bonus_e = bonus_life[p] & ~bonus_d[p];

        always_comb begin
            st_nxt    = st_q;
            lives_nxt = lives_q;
            tmr_nxt   = tmr_q;
            lost_nxt  = 1'b0;
            if (game_restart) begin
                st_nxt    = ALIVE;
                lives_nxt = START_L;
                tmr_nxt   = '0;
            end else begin
                case (st_q)
                    ALIVE: begin
                        // Hit wins over a simultaneous bonus.
                        if (hit_e) begin
                            lost_nxt = 1'b1;
                            if (lives_q > ONE_L) begin
                                lives_nxt = lives_q - ONE_L;
                                tmr_nxt   = TMR_LOAD;
                                st_nxt    = INVULN;
                            end else begin
                                lives_nxt = '0;
                                st_nxt    = DEAD;
                            end
                        end else if (bonus_e && (lives_q < MAX_L)) begin
                            lives_nxt = lives_q + ONE_L;
                        end
                    end
                    INVULN: begin
                        if (bonus_e && (lives_q < MAX_L)) begin
                            lives_nxt = lives_q + ONE_L;
                        end
                        if (tmr_q == '0) begin
                            st_nxt = ALIVE;
                        end else begin
                            tmr_nxt = tmr_q - TMR_W'(1);
                        end
                    end
                    DEAD: begin
                        lives_nxt = '0;
                    end
                    default: begin
                        st_nxt = ALIVE;
                    end
                endcase
            end
        end

        always_comb begin
            hmask_nxt = '0;
            for (int i = 0; i < MAX_LIVES; i++) begin
                hmask_nxt[i] = (int'(lives_nxt) > i);
            end
        end

        assign dead_nxt[p] = (st_nxt == DEAD);

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                st_q    <= ALIVE;
                lives_q <= START_L;
                tmr_q   <= '0;
                hmask_q <= START_MASK;
                inv_q   <= 1'b0;
                died_q  <= 1'b0;
                lost_q  <= 1'b0;
            end else begin
                st_q    <= st_nxt;
                lives_q <= lives_nxt;
                tmr_q   <= tmr_nxt;
                hmask_q <= hmask_nxt;
                inv_q   <= (st_nxt == INVULN);
                died_q  <= (st_nxt == DEAD);
                lost_q  <= lost_nxt;
            end
        end

        assign lives_count[p*LIFE_W +: LIFE_W]      = lives_q;
        assign heart_mask[p*MAX_LIVES +: MAX_LIVES] = hmask_q;
        assign invulnerable[p]                      = inv_q;
        assign player_died[p]                       = died_q;
        assign life_lost[p]                         = lost_q;
    end

    // DEAD is sticky until restart, so "all next-states DEAD" is already sticky.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            game_over <= 1'b0;
        end else begin
            game_over <= &dead_nxt;
        end
    end

endmodule

// File: tb/tb_lives_manager.sv
module tb_lives_manager;

    localparam int NP  = 2;
    localparam int ML  = 5;
    localparam int SL  = 3;
    localparam int INV = 4;
    localparam int LW  = $clog2(ML + 1);

    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic              game_restart = 1'b0;
    logic [NP-1:0]     hit = '0;
    logic [NP-1:0]     bonus_life = '0;
    logic [NP*LW-1:0]  lives_count;
    logic [NP*ML-1:0]  heart_mask;
    logic [NP-1:0]     invulnerable;
    logic [NP-1:0]     player_died;
    logic [NP-1:0]     life_lost;
    logic              game_over;

    lives_manager #(
        .NUM_PLAYERS  (NP),
        .MAX_LIVES    (ML),
        .START_LIVES  (SL),
        .INVULN_CYCLES(INV)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .game_restart(game_restart),
        .hit         (hit),
        .bonus_life  (bonus_life),
        .lives_count (lives_count),
        .heart_mask  (heart_mask),
        .invulnerable(invulnerable),
        .player_died (player_died),
        .life_lost   (life_lost),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP*LW-1:0] lc;
        logic [NP*ML-1:0] hm;
        logic [NP-1:0]    inv;
        logic [NP-1:0]    died;
        logic [NP-1:0]    lost;
        logic             go;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    // Reference model: per-player life count, remaining invulnerable cycles,
    // death flag and previous input levels.
    int m_lives[NP];
    int m_inv[NP];
    bit m_dead[NP];
    bit m_lost[NP];
    bit m_ph[NP];
    bit m_pb[NP];

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) begin
            m_lives[p] = SL;
            m_inv[p]   = 0;
            m_dead[p]  = 1'b0;
            m_lost[p]  = 1'b0;
            m_ph[p]    = 1'b0;
            m_pb[p]    = 1'b0;
        end
    endfunction

    function automatic void model_step(input logic [NP-1:0] h, input logic [NP-1:0] b,
                                       input logic r);
        for (int p = 0; p < NP; p++) begin
            bit he;
            bit be;
            he = h[p] && !m_ph[p];
            be = b[p] && !m_pb[p];
            m_ph[p] = h[p];
            m_pb[p] = b[p];
            m_lost[p] = 1'b0;
            if (r) begin
                m_lives[p] = SL;
                m_inv[p]   = 0;
                m_dead[p]  = 1'b0;
            end else if (m_dead[p]) begin
                m_lives[p] = 0;
            end else if (m_inv[p] > 0) begin
                m_inv[p] = m_inv[p] - 1;
                if (be && m_lives[p] < ML) m_lives[p] = m_lives[p] + 1;
            end else if (he) begin
                m_lost[p]  = 1'b1;
                m_lives[p] = m_lives[p] - 1;
                if (m_lives[p] == 0) m_dead[p] = 1'b1;
                else m_inv[p] = INV;
            end else if (be && m_lives[p] < ML) begin
                m_lives[p] = m_lives[p] + 1;
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.go = 1'b1;
        for (int p = 0; p < NP; p++) begin
            e.lc[p*LW +: LW] = LW'(m_lives[p]);
            for (int i = 0; i < ML; i++) e.hm[p*ML + i] = (m_lives[p] > i);
            e.inv[p]  = (m_inv[p] > 0);
            e.died[p] = m_dead[p];
            e.lost[p] = m_lost[p];
            e.go      = e.go & m_dead[p];
        end
        exp_q.push_back(e);
    endfunction

    function automatic void chk(input string name, input logic [31:0] got,
                                input logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endfunction

    // Monitor: one expected entry per sampled clock edge or async reset assertion.
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(posedge clk or negedge resetN);
            #1;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                e = exp_q.pop_front();
                vectors++;
                chk("lives_count",  32'(lives_count),  32'(e.lc));
                chk("heart_mask",   32'(heart_mask),   32'(e.hm));
                chk("invulnerable", 32'(invulnerable), 32'(e.inv));
                chk("player_died",  32'(player_died),  32'(e.died));
                chk("life_lost",    32'(life_lost),    32'(e.lost));
                chk("game_over",    32'(game_over),    32'(e.go));
            end
        end
    end

    task automatic cycle(input logic [NP-1:0] h, input logic [NP-1:0] b, input logic r);
        @(negedge clk);
        hit = h;
        bonus_life = b;
        game_restart = r;
        resetN = 1'b1;
        model_step(h, b, r);
        push_exp();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle('0, '0, 1'b0);
    endtask

    // Drop reset between edges; one entry for the immediate check, one for the
    // following posedge, one more for the next held cycle.
    task automatic async_reset(input logic [NP-1:0] h);
        @(negedge clk);
        #2;
        hit = h;
        bonus_life = '0;
        game_restart = 1'b0;
        resetN = 1'b0;
        model_reset();
        push_exp();
        push_exp();
        @(negedge clk);
        push_exp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got timeout expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        push_exp();
        mon_en = 1'b1;

        // single hit on player 0, invulnerability window
        cycle(2'b01, 2'b00, 1'b0);
        idle(6);
        cycle(2'b00, 2'b01, 1'b0);
        idle(1);
        // held hit counts once
        repeat (20) cycle(2'b01, 2'b00, 1'b0);
        idle(1);
        // hit, then a second edge during INVULN
        cycle(2'b01, 2'b00, 1'b0);
        idle(1);
        cycle(2'b01, 2'b00, 1'b0);
        idle(6);
        // bonuses to saturation on player 1, then hit+bonus together
        repeat (4) begin
            cycle(2'b00, 2'b10, 1'b0);
            idle(1);
        end
        cycle(2'b10, 2'b10, 1'b0);
        idle(6);
        // kill player 0, then player 1
        repeat (3) begin
            cycle(2'b01, 2'b00, 1'b0);
            idle(6);
        end
        repeat (5) begin
            cycle(2'b10, 2'b00, 1'b0);
            idle(6);
        end
        // restart, then restart mid-INVULN with simultaneous hit
        cycle(2'b00, 2'b00, 1'b1);
        cycle(2'b10, 2'b00, 1'b0);
        idle(1);
        cycle(2'b10, 2'b00, 1'b1);
        idle(3);
        // async reset between edges, released with hit[0] held
        cycle(2'b01, 2'b00, 1'b0);
        async_reset(2'b01);
        cycle(2'b01, 2'b00, 1'b0);
        cycle(2'b01, 2'b00, 1'b0);
        idle(6);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [NP-1:0] h;
            logic [NP-1:0] b;
            logic r;
            for (int p = 0; p < NP; p++) begin
                h[p] = ($urandom_range(0, 3) == 0);
                b[p] = ($urandom_range(0, 4) == 0);
            end
            r = ($urandom_range(0, 59) == 0);
            cycle(h, b, r);
        end
        idle(2);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
